// File: rtl/clk_pkg.sv
// clk_pkg: shared word width and word type for the alarm-clock datapath
package clk_pkg;
  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mux_n.sv
// mux_n: W-bit 2:1 mux, sel=1 picks a
module mux_n #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? a : b;
endmodule

// File: rtl/mux_advanced.sv
// mux_advanced: registered display word selection and alarm-match buzzer request
module mux_advanced
  import clk_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alarm_data,
  input  logic [WIDTH-1:0] time_data,
  input  logic [WIDTH-1:0] set_data,
  input  logic             show_alarm,
  input  logic             show_time,
  input  logic             alarm_on,
  output logic [WIDTH-1:0] display,
  output logic             sound_alarm
);
  logic [WIDTH-1:0] m0_y, display_d, display_q;
  logic             match, sound_d, sound_q;
  assign match = alarm_data == time_data;
  mux_n #(.W(WIDTH)) m0 (.a(alarm_data), .b(set_data), .sel(show_alarm), .y(m0_y));
  mux_n #(.W(WIDTH)) m1 (.a(time_data), .b(m0_y), .sel(show_time), .y(display_d));
  mux_n #(.W(1))     m2 (.a(match), .b(1'b0), .sel(alarm_on), .y(sound_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= '0;
      sound_q   <= 1'b0;
    end else begin
      display_q <= display_d;
      sound_q   <= sound_d;
    end
  end
  assign display     = display_q;
  assign sound_alarm = sound_q;
endmodule

// File: tb/tb_mux_advanced.sv
// tb_mux_advanced: directed vectors with hand-computed expectations for mux_advanced
module tb_mux_advanced;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alarm_data, time_data, set_data, display;
  logic        show_alarm, show_time, alarm_on, sound_alarm;
  int          n_vec = 0;
  int          n_err = 0;

  mux_advanced dut (
    .clk(clk), .rst_n(rst_n), .alarm_data(alarm_data), .time_data(time_data),
    .set_data(set_data), .show_alarm(show_alarm), .show_time(show_time),
    .alarm_on(alarm_on), .display(display), .sound_alarm(sound_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    alarm_data = 16'd11; time_data = 16'd5; set_data = 16'd19;
    show_time = 1'b1; show_alarm = 1'b1; alarm_on = 1'b1;
    #1;
    chk("rst_disp_imm", display, 16'd0);
    chk("rst_snd_imm", {15'd0, sound_alarm}, 16'd0);
    step();
    chk("rst_disp_held", display, 16'd0);
    time_data = 16'd11;
    rst_n = 1'b1;
    #1;
    chk("rel_disp_pre", display, 16'd0);
    chk("rel_snd_pre", {15'd0, sound_alarm}, 16'd0);
    // test 2
    time_data = 16'd5; show_alarm = 1'b0;
    step();
    chk("t2_disp", display, 16'd5);
    chk("t2_snd", {15'd0, sound_alarm}, 16'd0);
    // test 3: sweep 6..13, alarm fires only for time=11
    for (int t = 6; t <= 13; t++) begin
      time_data = 16'(t);
      step();
      chk($sformatf("t3_disp_%0d", t), display, 16'(t));
      chk($sformatf("t3_snd_%0d", t), {15'd0, sound_alarm}, (t == 11) ? 16'd1 : 16'd0);
    end
    // alarm_on clearing drops the buzzer next cycle
    time_data = 16'd11;
    step();
    chk("on_snd", {15'd0, sound_alarm}, 16'd1);
    alarm_on = 1'b0;
    step();
    chk("off_snd", {15'd0, sound_alarm}, 16'd0);
    // full-width compare: upper bits differ
    alarm_on = 1'b1; alarm_data = 16'h8011; time_data = 16'h0011;
    step();
    chk("wide_snd", {15'd0, sound_alarm}, 16'd0);
    alarm_data = 16'h1234; time_data = 16'h1235;
    step();
    chk("lsb_snd", {15'd0, sound_alarm}, 16'd0);
    alarm_data = 16'h1235;
    step();
    chk("eq_snd", {15'd0, sound_alarm}, 16'd1);
    // test 4
    alarm_data = 16'd65; alarm_on = 1'b0;
    for (int t = 63; t <= 67; t++) begin
      time_data = 16'(t);
      step();
      chk($sformatf("t4_snd_%0d", t), {15'd0, sound_alarm}, 16'd0);
      chk($sformatf("t4_disp_%0d", t), display, 16'(t));
    end
    // test 5
    show_time = 1'b0; show_alarm = 1'b0; time_data = 16'd70;
    step();
    chk("t5_set", display, 16'd19);
    show_alarm = 1'b1;
    step();
    chk("t5_alarm", display, 16'd65);
    show_time = 1'b1;
    step();
    chk("t5_time", display, 16'd70);
    // simultaneous changes land on the same edge
    show_time = 1'b0; set_data = 16'h0945; show_alarm = 1'b0;
    step();
    chk("t5_simul", display, 16'h0945);
    // test 6
    show_time = 1'b1; alarm_on = 1'b1; alarm_data = 16'd11; time_data = 16'd11;
    step();
    chk("t6_snd_pre", {15'd0, sound_alarm}, 16'd1);
    chk("t6_disp_pre", display, 16'd11);
    rst_n = 1'b0;
    #1;
    chk("t6_disp_async", display, 16'd0);
    chk("t6_snd_async", {15'd0, sound_alarm}, 16'd0);
    step();
    chk("t6_disp_hold", display, 16'd0);
    rst_n = 1'b1; time_data = 16'd12;
    #1;
    chk("t6_disp_rel", display, 16'd0);
    step();
    chk("t6_disp_resume", display, 16'd12);
    chk("t6_snd_resume", {15'd0, sound_alarm}, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
